// File: rtl/inv_subbytes_seq_pkg.sv
// inv_subbytes_pkg: shared types for the inv_subbytes_seq slice.
//   fsm_state_t : sequencer states (IDLE, SUB, DONE)
//   STATE_BYTES : bytes in one AES state
//   byte_t      : one state byte
package inv_subbytes_pkg;

    localparam int STATE_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/inv_subbytes_seq_if.sv
// inv_subbytes_seq_if: valid/ready bus around inv_subbytes_seq.
//   in_valid/in_ready/in_state    : block input (byte i = in_state[127-8i -: 8])
//   out_valid/out_ready/out_state : substituted block output
//   bypass                        : only with INV_SUBBYTES_BYPASS_EN defined
// modport master = upstream/downstream side, slave = the sequencer.
interface inv_subbytes_seq_if;
    import inv_subbytes_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [STATE_BYTES*8-1:0]   in_state;
    logic                       out_valid;
    logic                       out_ready;
    logic [STATE_BYTES*8-1:0]   out_state;
`ifdef INV_SUBBYTES_BYPASS_EN
    logic                       bypass;

    modport master (output in_valid, in_state, bypass, out_ready,
                    input  in_ready, out_valid, out_state);
    modport slave  (input  in_valid, in_state, bypass, out_ready,
                    output in_ready, out_valid, out_state);
`else
    modport master (output in_valid, in_state, out_ready,
                    input  in_ready, out_valid, out_state);
    modport slave  (input  in_valid, in_state, out_ready,
                    output in_ready, out_valid, out_state);
`endif

endinterface

// File: rtl/inv_subbytes_seq_inv_sbox.sv
// inv_sbox: combinational AES inverse S-box.
//   a : input byte
//   y : InvSubBytes(a)
module inv_sbox
    import inv_subbytes_pkg::*;
(
    input  byte_t a,
    output byte_t y
);

    // Row r holds entries 16r..16r+15; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = TBL[a];

endmodule

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: InvSubBytes over a 128-bit state, LANES bytes per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : inv_subbytes_seq_if.slave (in/out valid/ready + state)
//   busy       : FSM not in IDLE
// LANES must be 1, 2, 4, 8 or 16; a block takes BEATS = 16/LANES cycles.
// Optional: INV_SUBBYTES_BYPASS_EN adds bus.bypass; a block accepted with
// bypass set passes through unchanged with identical timing.
module inv_subbytes_seq
    import inv_subbytes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_subbytes_seq_if.slave    bus,
    output logic                 busy
);

    localparam int BEATS = STATE_BYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    fsm_state_t                 st;
    logic [BW-1:0]              beat;
    logic                       ov_q;
    // Ascending declaration so sreg[i] is byte i = bits [127-8i -: 8].
    byte_t [0:STATE_BYTES-1]    sreg, sreg_nxt;
    byte_t [LANES-1:0]          sb_in, sb_out;
    logic  [LANES-1:0][3:0]     idx;
    logic  [3:0]                base;
`ifdef INV_SUBBYTES_BYPASS_EN
    logic                       byp_q;
`endif

    // in_ready depends on out_ready in DONE so a new block can be taken on
    // the same edge that retires the old one.
    assign bus.in_ready  = (st == IDLE) || ((st == DONE) && bus.out_ready);
    assign bus.out_valid = ov_q;
    assign bus.out_state = sreg;

    // Lane l handles byte beat*LANES + l.
    always_comb begin
        base = 4'(int'(beat) * LANES);
        for (int l = 0; l < LANES; l++) begin
            idx[l]   = base + 4'(l);
            sb_in[l] = sreg[idx[l]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
    end

    // Only the current group changes; the rest of the state is held.
    always_comb begin
        sreg_nxt = sreg;
        for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUBBYTES_BYPASS_EN
            if (!byp_q)
                sreg_nxt[idx[l]] = sb_out[l];
`else
            sreg_nxt[idx[l]] = sb_out[l];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= IDLE;
            beat <= '0;
            sreg <= '0;
            ov_q <= 1'b0;
            busy <= 1'b0;
`ifdef INV_SUBBYTES_BYPASS_EN
            byp_q <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg <= bus.in_state;
                        beat <= '0;
                        busy <= 1'b1;
                        st   <= SUB;
`ifdef INV_SUBBYTES_BYPASS_EN
                        byp_q <= bus.bypass;
`endif
                    end
                end
                SUB: begin
                    sreg <= sreg_nxt;
                    if (beat == LAST) begin
                        beat <= '0;
                        ov_q <= 1'b1;
                        st   <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q <= 1'b0;
                        if (bus.in_valid) begin
                            // Retire and accept on the same edge.
                            sreg <= bus.in_state;
                            beat <= '0;
                            st   <= SUB;
`ifdef INV_SUBBYTES_BYPASS_EN
                            byp_q <= bus.bypass;
`endif
                        end else begin
                            busy <= 1'b0;
                            st   <= IDLE;
                        end
                    end
                end
                default: begin
                    st   <= IDLE;
                    ov_q <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
module tb_inv_subbytes_seq;
    localparam int LANES = 4;
    localparam int BEATS = 16 / LANES;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    inv_subbytes_seq_if bus ();

    inv_subbytes_seq #(.LANES(LANES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [127:0] din;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_byp(input logic b);
`ifdef INV_SUBBYTES_BYPASS_EN
        bus.bypass = b;
`else
        if (b) $display("note: bypass vector in a build without bypass");
`endif
    endtask

    // One block: accept, measure latency, check data and handshakes, retire.
    task automatic run_vec(input string nm, input logic [127:0] d, input logic byp,
                           input logic [127:0] exp);
        int lat;
        bit got;
        @(negedge clk);
        chk({nm, " in_ready idle"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.in_state  = d;
        bus.out_ready = 1'b0;
        set_byp(byp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_state = ~d;
        set_byp(1'b0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (bus.out_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({nm, " latency"}, 128'(lat), 128'(BEATS));
        chk({nm, " data"}, bus.out_state, exp);
        chk({nm, " busy done"}, 128'(busy), 128'(1));
        chk({nm, " in_ready done"}, 128'(bus.in_ready), 128'(0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, " retire"}, 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int           tv[2];
        logic [127:0] sv[2];
        int           n;
        bit           stray;

        vt.push_back('{"seq00", 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                       128'h52096ad53036a538bf40a39e81f3d7fb});
        vt.push_back('{"seq10", 128'h101112131415161718191a1b1c1d1e1f, 1'b0,
                       128'h7ce339829b2fff87348e4344c4dee9cb});
        vt.push_back('{"seqf0", 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 1'b0,
                       128'h172b047eba77d626e169146355210c7d});
        vt.push_back('{"all63", {16{8'h63}}, 1'b0, {16{8'h00}}});
        vt.push_back('{"allff", {16{8'hff}}, 1'b0, {16{8'h7d}}});
`ifdef INV_SUBBYTES_BYPASS_EN
        vt.push_back('{"byp63", {16{8'h63}}, 1'b1, {16{8'h63}}});
        vt.push_back('{"after_byp", {16{8'h63}}, 1'b0, {16{8'h00}}});
`endif

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
        set_byp(1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst out_state", bus.out_state, 128'h0);

        foreach (vt[i]) run_vec(vt[i].nm, vt[i].din, vt[i].byp, vt[i].exp);

        // Backpressure: hold DONE for 10 cycles, then retire in one.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_state = {16{8'h00}};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (BEATS) @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp out_valid c%0d", c), 128'(bus.out_valid), 128'(1));
            chk($sformatf("bp data c%0d", c), bus.out_state, {16{8'h52}});
            chk($sformatf("bp in_ready c%0d", c), 128'(bus.in_ready), 128'(0));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp retire out_valid", 128'(bus.out_valid), 128'(0));
        chk("bp retire busy", 128'(busy), 128'(0));
        bus.out_ready = 1'b0;

        // Back-to-back: second block taken on the edge that retires the first.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_state  = {16{8'h7c}};
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_state = {16{8'h52}};
        n = 0;
        tv[0] = -100;
        tv[1] = -100;
        sv[0] = '0;
        sv[1] = '0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (n < 2) begin
                    tv[n] = c;
                    sv[n] = bus.out_state;
                end
                n++;
            end
            if (n == 1 && c == tv[0] + 1) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b count", 128'(n), 128'(2));
        chk("b2b first latency", 128'(tv[0]), 128'(BEATS));
        chk("b2b spacing", 128'(tv[1] - tv[0]), 128'(BEATS + 1));
        chk("b2b data0", sv[0], {16{8'h01}});
        chk("b2b data1", sv[1], {16{8'h48}});

        // Reset mid-SUB abandons the block.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_state = {16{8'hff}};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst out_valid c%0d", c), 128'(bus.out_valid), 128'(0));
            chk($sformatf("midrst busy c%0d", c), 128'(busy), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst in_ready", 128'(bus.in_ready), 128'(1));
        chk("midrst out_state", bus.out_state, 128'h0);
        chk("midrst busy after", 128'(busy), 128'(0));
        stray = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk("midrst no stray out_valid", 128'(stray), 128'(0));

        run_vec("post_rst", {16{8'h7c}}, 1'b0, {16{8'h01}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
